// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-file geometry defaults and read-port address extraction.
package pipe_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned NREG       = 2 ** ADDR_W_DEF;

  // Upper bounds for the generic slice helper; instantiations must stay within them.
  localparam int unsigned ADDR_W_MAX = 16;
  localparam int unsigned RD_VEC_MAX = 128;

  // Returns port k's index from a packed vector of aw-bit fields, zero-extended to ADDR_W_MAX.
  function automatic logic [ADDR_W_MAX-1:0] port_addr(
    input logic [RD_VEC_MAX-1:0] vec,
    input int unsigned           k,
    input int unsigned           aw
  );
    logic [RD_VEC_MAX-1:0] shifted;
    logic [ADDR_W_MAX:0]   mask;
    shifted = vec >> (k * aw);
    mask    = ((ADDR_W_MAX+1)'(1) << aw) - (ADDR_W_MAX+1)'(1);
    return shifted[ADDR_W_MAX-1:0] & mask[ADDR_W_MAX-1:0];
  endfunction

endpackage

// File: rtl/regfile_sb_bits.sv
// Pending-load scoreboard: one busy bit per register plus an incrementally kept popcount.
module regfile_sb_bits
  import pipe_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_en,
  input  logic [ADDR_W-1:0]       clr_addr,
  input  logic                    set_en,
  input  logic [ADDR_W-1:0]       set_addr,
  output logic [(2**ADDR_W)-1:0]  busy,
  output logic [ADDR_W:0]         pending_cnt
);

  localparam int unsigned NENT = 2 ** ADDR_W;
  localparam bit          ZR   = (ZERO_REG != 0);

  logic [NENT-1:0] busy_nxt;
  logic [ADDR_W:0] cnt_nxt;
  logic            set_eff;
  logic            inc;
  logic            dec;

  always_comb begin
    set_eff  = set_en && !(ZR && (set_addr == '0));
    busy_nxt = busy;
    if (clr_en)
      busy_nxt[clr_addr] = 1'b0;
    if (set_eff)
      busy_nxt[set_addr] = 1'b1;
    if (ZR)
      busy_nxt[0] = 1'b0;

    // A set landing on the index being cleared wins, so that clear never removes a bit.
    inc = set_eff && !busy[set_addr];
    dec = clr_en && busy[clr_addr] && !(set_eff && (set_addr == clr_addr));
    cnt_nxt = pending_cnt + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy        <= '0;
      pending_cnt <= '0;
    end else begin
      busy        <= busy_nxt;
      pending_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file: posedge write, write-to-read bypass, optional zero register, load-use scoreboard.
module regfile_scoreboard
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NRD*ADDR_W-1:0]   rd_addr,
  input  logic [NRD-1:0]          rd_en,
  output logic [NRD*DATA_W-1:0]   rd_data,
  output logic [NRD-1:0]          rd_busy,
  output logic                    stall,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       wa,
  input  logic [DATA_W-1:0]       wd,
  input  logic                    sb_set,
  input  logic [ADDR_W-1:0]       sb_addr,
  output logic [ADDR_W:0]         pending_cnt
);

  localparam int unsigned NENT = 2 ** ADDR_W;
  localparam bit          ZR   = (ZERO_REG != 0);

  logic [DATA_W-1:0]     mem [NENT];
  logic [NENT-1:0]       busy;
  logic [RD_VEC_MAX-1:0] rd_vec;
  logic [ADDR_W-1:0]     ra [NRD];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NENT; i++)
        mem[i] <= '0;
    end else if (we && !(ZR && (wa == '0))) begin
      mem[wa] <= wd;
    end
  end

  regfile_sb_bits #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb_bits (
    .clk         (clk),
    .rst         (rst),
    .clr_en      (we),
    .clr_addr    (wa),
    .set_en      (sb_set),
    .set_addr    (sb_addr),
    .busy        (busy),
    .pending_cnt (pending_cnt)
  );

  assign rd_vec = RD_VEC_MAX'(rd_addr);

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      ra[k] = ADDR_W'(port_addr(rd_vec, k, ADDR_W));
      if (ZR && (ra[k] == '0))
        rd_data[k*DATA_W +: DATA_W] = '0;
      else if (we && (wa == ra[k]))
        rd_data[k*DATA_W +: DATA_W] = wd;
      else
        rd_data[k*DATA_W +: DATA_W] = mem[ra[k]];
      // A writeback landing this cycle is forwarded, so it resolves the hazard immediately.
      rd_busy[k] = busy[ra[k]] && !(we && (wa == ra[k]));
    end
  end

  assign stall = |(rd_en & rd_busy);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed scoreboard bench for regfile_scoreboard (default geometry, two read ports).
module tb_regfile_scoreboard;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  typedef enum logic [2:0] {K_RD0, K_RD1, K_BUSY, K_STALL, K_CNT} kind_t;
  typedef struct {
    kind_t       kind;
    string       tag;
    logic [63:0] exp;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [2*AW-1:0] rd_addr;
  logic [1:0]      rd_en;
  logic [2*DW-1:0] rd_data;
  logic [1:0]      rd_busy;
  logic            stall;
  logic            we;
  logic [AW-1:0]   wa;
  logic [DW-1:0]   wd;
  logic            sb_set;
  logic [AW-1:0]   sb_addr;
  logic [AW:0]     pending_cnt;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NRD      (2),
    .ZERO_REG (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .stall       (stall),
    .we          (we),
    .wa          (wa),
    .wd          (wd),
    .sb_set      (sb_set),
    .sb_addr     (sb_addr),
    .pending_cnt (pending_cnt)
  );

  task automatic expect_val(input kind_t kind, input string tag, input logic [63:0] exp);
    exp_t e;
    e.kind = kind;
    e.tag  = tag;
    e.exp  = exp;
    q.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [63:0] obs;
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.kind)
        K_RD0:   obs = 64'(rd_data[DW-1:0]);
        K_RD1:   obs = 64'(rd_data[2*DW-1:DW]);
        K_BUSY:  obs = 64'(rd_busy);
        K_STALL: obs = 64'(stall);
        default: obs = 64'(pending_cnt);
      endcase
      n_checks++;
      assert (obs === e.exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ports(input logic [AW-1:0] a1, input logic [AW-1:0] a0, input logic [1:0] en);
    rd_addr = {a1, a0};
    rd_en   = en;
  endtask

  initial begin
    rst = 1'b0; rd_addr = '0; rd_en = '0; we = 1'b0; wa = '0; wd = '0;
    sb_set = 1'b0; sb_addr = '0;
    step();
    rst = 1'b1;

    // reset state over every address, both ports
    for (int a = 0; a < 32; a++) begin
      ports(AW'(a), AW'(a), 2'b11);
      expect_val(K_RD0, $sformatf("rst_rd0_%0d", a), 64'd0);
      expect_val(K_RD1, $sformatf("rst_rd1_%0d", a), 64'd0);
      expect_val(K_BUSY, $sformatf("rst_busy_%0d", a), 64'd0);
      expect_val(K_STALL, $sformatf("rst_stall_%0d", a), 64'd0);
      check_all();
    end
    expect_val(K_CNT, "rst_cnt", 64'd0);
    check_all();

    // write with same-cycle bypass, then stored value
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    ports(5'd0, 5'd5, 2'b00);
    expect_val(K_RD0, "bypass_rd0", 64'hDEADBEEF);
    check_all();
    step();
    we = 1'b0;
    expect_val(K_RD0, "stored_rd0", 64'hDEADBEEF);
    check_all();

    // zero register ignores writes and scoreboard sets
    we = 1'b1; wa = 5'd0; wd = 32'h1234; sb_set = 1'b1; sb_addr = 5'd0;
    ports(5'd0, 5'd0, 2'b11);
    expect_val(K_RD0, "zero_bypass_rd0", 64'd0);
    check_all();
    step();
    we = 1'b0; sb_set = 1'b0;
    expect_val(K_RD0, "zero_rd0", 64'd0);
    expect_val(K_BUSY, "zero_busy", 64'd0);
    expect_val(K_CNT, "zero_cnt", 64'd0);
    check_all();

    // load-use hazard on register 8
    sb_set = 1'b1; sb_addr = 5'd8;
    step();
    sb_set = 1'b0;
    ports(5'd8, 5'd0, 2'b10);
    expect_val(K_BUSY, "lu_busy", 64'b10);
    expect_val(K_STALL, "lu_stall", 64'd1);
    expect_val(K_CNT, "lu_cnt", 64'd1);
    check_all();
    ports(5'd8, 5'd8, 2'b01);
    expect_val(K_BUSY, "lu_same_busy", 64'b11);
    expect_val(K_STALL, "lu_same_stall", 64'd1);
    expect_val(K_RD0, "lu_same_rd0", 64'd0);
    expect_val(K_RD1, "lu_same_rd1", 64'd0);
    check_all();
    ports(5'd8, 5'd0, 2'b10);
    we = 1'b1; wa = 5'd8; wd = 32'h55;
    expect_val(K_STALL, "lu_wb_stall", 64'd0);
    expect_val(K_BUSY, "lu_wb_busy", 64'd0);
    expect_val(K_RD1, "lu_wb_rd1", 64'h55);
    expect_val(K_CNT, "lu_wb_cnt_before", 64'd1);
    check_all();
    step();
    we = 1'b0;
    expect_val(K_CNT, "lu_cnt_after", 64'd0);
    expect_val(K_RD1, "lu_rd1_after", 64'h55);
    check_all();

    // set/clear collision on an already-busy register
    sb_set = 1'b1; sb_addr = 5'd3;
    step();
    we = 1'b1; wa = 5'd3; wd = 32'h77;
    step();
    sb_set = 1'b0; we = 1'b0;
    ports(5'd3, 5'd3, 2'b00);
    expect_val(K_BUSY, "coll_busy", 64'b11);
    expect_val(K_STALL, "coll_stall_noen", 64'd0);
    expect_val(K_CNT, "coll_cnt", 64'd1);
    expect_val(K_RD0, "coll_rd0", 64'h77);
    check_all();

    // collision on an idle register still marks it pending; duplicate set counts once
    sb_set = 1'b1; sb_addr = 5'd6; we = 1'b1; wa = 5'd6; wd = 32'h66;
    step();
    sb_addr = 5'd10; we = 1'b0;
    step();
    step();
    sb_set = 1'b0;
    expect_val(K_CNT, "coll_idle_dup_cnt", 64'd3);
    check_all();
    we = 1'b1; wa = 5'd7;
    step();
    we = 1'b0;
    expect_val(K_CNT, "clr_idle_cnt", 64'd3);
    check_all();
    we = 1'b1; wa = 5'd3;
    step();
    wa = 5'd6;
    step();
    wa = 5'd10;
    step();
    we = 1'b0;
    expect_val(K_CNT, "drain_cnt", 64'd0);
    check_all();

    // reset with loads outstanding, plus last-entry clear
    we = 1'b1; wa = 5'd31; wd = 32'hA5A5A5A5;
    step();
    we = 1'b0;
    sb_set = 1'b1; sb_addr = 5'd2;
    step();
    sb_addr = 5'd4;
    step();
    sb_addr = 5'd9;
    step();
    sb_set = 1'b0;
    ports(5'd31, 5'd31, 2'b00);
    expect_val(K_CNT, "mid_cnt3", 64'd3);
    expect_val(K_RD1, "mid_rd31", 64'hA5A5A5A5);
    check_all();
    rst = 1'b0; we = 1'b1; wa = 5'd12; wd = 32'h1; sb_set = 1'b1; sb_addr = 5'd13;
    step();
    rst = 1'b1; we = 1'b0; sb_set = 1'b0;
    ports(5'd4, 5'd2, 2'b11);
    expect_val(K_CNT, "mid_rst_cnt", 64'd0);
    expect_val(K_STALL, "mid_rst_stall", 64'd0);
    expect_val(K_BUSY, "mid_rst_busy", 64'd0);
    check_all();
    ports(5'd12, 5'd31, 2'b11);
    expect_val(K_RD0, "mid_rst_rd31", 64'd0);
    expect_val(K_RD1, "mid_rst_rd12", 64'd0);
    check_all();
    ports(5'd13, 5'd9, 2'b11);
    expect_val(K_BUSY, "mid_rst_busy13", 64'd0);
    check_all();
    we = 1'b1; wa = 5'd4; wd = 32'h44;
    step();
    we = 1'b0;
    expect_val(K_CNT, "late_wb_cnt", 64'd0);
    check_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
